// File: rtl/vr_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vr_rr_arbiter
//
// Round-robin arbiter that multiplexes N valid/ready producers into one
// registered, one-entry output stage with full-throughput backpressure.
//
// Optional feature (compile-time macro VR_ARB_BURST_EN):
//   When defined, a granted requester keeps the grant for up to MAX_BURST
//   consecutive accepted beats (ARB/LOCK FSM). When undefined, the grant
//   rotates on every accepted beat.
//
// Parameters:
//   N         number of requesters (2..16)
//   W         data width per beat
//   MAX_BURST beats per locked grant (1..255), burst build only
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   in_valid   [N]     per-requester valid
//   in_data    [N*W]   requester i data at [i*W +: W]
//   in_ready   [N]     per-requester ready, one-hot or zero
//   out_valid          output stage holds a beat
//   out_data   [W]     registered beat
//   out_ready          consumer ready
//   grant_idx  [log2N] requester that supplied the registered beat
// -----------------------------------------------------------------------------
module vr_rr_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  // Increment modulo N, used for every priority-pointer update.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    if (v == IW'(N - 1)) begin
      r = '0;
    end else begin
      r = v + IW'(1);
    end
    return r;
  endfunction

  logic            valid_r;
  logic [W-1:0]    data_r;
  logic [IW-1:0]   grant_r;
  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   ptr_nxt_s;
  logic [IW-1:0]   rr_sel_s;
  logic [IW-1:0]   sel_s;
  logic            any_req_s;
  logic            stage_free_s;
  logic            accept_s;

  assign any_req_s    = |in_valid;
  assign stage_free_s = ~valid_r | out_ready;

  // Round-robin search starting at ptr_r; walking from the far end back
  // toward ptr_r lets the nearest requesting index win.
  always_comb begin
    rr_sel_s = ptr_r;
    for (int k = N - 1; k >= 0; k--) begin : search
      logic [IW:0] cand_w;
      cand_w = {1'b0, ptr_r} + (IW + 1)'(k);
      if (cand_w >= (IW + 1)'(N)) begin
        cand_w = cand_w - (IW + 1)'(N);
      end else begin
        cand_w = cand_w;
      end
      if (in_valid[cand_w[IW-1:0]]) begin
        rr_sel_s = cand_w[IW-1:0];
      end else begin
        rr_sel_s = rr_sel_s;
      end
    end
  end

`ifdef VR_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IW-1:0]   owner_r;
  logic [IW-1:0]   owner_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic [CW-1:0]   cnt_inc_s;
  logic            lock_drop_s;

  assign cnt_inc_s   = cnt_r + CW'(1);
  // The owner releasing valid mid-burst ends the lock without a beat.
  assign lock_drop_s = (state_r == LOCK) & ~in_valid[owner_r];
  assign sel_s       = (state_r == LOCK) ? owner_r : rr_sel_s;
  assign accept_s    = ~rst & any_req_s & stage_free_s & ~lock_drop_s;

  // Burst FSM state, owner and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ARB;
      owner_r <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state, lock bookkeeping and pointer update.
  always_comb begin
    state_s   = state_r;
    owner_s   = owner_r;
    cnt_s     = cnt_r;
    ptr_nxt_s = ptr_r;
    case (state_r)
      ARB: begin
        if (accept_s && (MAX_BURST > 1)) begin
          state_s = LOCK;
          owner_s = sel_s;
          cnt_s   = CW'(1);
        end else if (accept_s) begin
          ptr_nxt_s = wrap_inc(sel_s);
        end else begin
          state_s = ARB;
        end
      end
      LOCK: begin
        if (lock_drop_s) begin
          state_s   = ARB;
          ptr_nxt_s = wrap_inc(owner_r);
        end else if (accept_s && (cnt_inc_s == CW'(MAX_BURST))) begin
          state_s   = ARB;
          cnt_s     = cnt_inc_s;
          ptr_nxt_s = wrap_inc(owner_r);
        end else if (accept_s) begin
          cnt_s = cnt_inc_s;
        end else begin
          state_s = LOCK;
        end
      end
      default: begin
        state_s = ARB;
      end
    endcase
  end
`else
  assign sel_s    = rr_sel_s;
  assign accept_s = ~rst & any_req_s & stage_free_s;

  // Grant rotates past the winner on every accepted beat.
  always_comb begin
    if (accept_s) begin
      ptr_nxt_s = wrap_inc(sel_s);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end
`endif

  // Ready is combinational so a free stage can take a beat every cycle.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = accept_s & (sel_s == IW'(i));
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

  // One-entry output stage; accept has precedence over drain so a beat
  // arriving while the old one leaves replaces it without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      grant_r <= '0;
    end else if (accept_s) begin
      valid_r <= 1'b1;
      data_r  <= in_data[sel_s*W +: W];
      grant_r <= sel_s;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign grant_idx = grant_r;

endmodule

// File: tb/tb_vr_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vr_rr_arbiter
//
// Directed self-checking bench for vr_rr_arbiter (N=4, W=8, MAX_BURST=4).
// Burst-lock scenarios are compiled when VR_ARB_BURST_EN is defined; the
// rotating-grant scenarios otherwise.
// -----------------------------------------------------------------------------
module tb_vr_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [1:0]     grant_idx;

  int n_cmp;
  int n_err;

  vr_rr_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_idx (grant_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

`ifndef VR_ARB_BURST_EN
  logic [7:0] rr_exp [5];
`else
  logic [1:0] bst_exp [9];
`endif

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b0;

    // Reset state: requests present but nothing ready or valid.
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_grant", grant_idx, 2'd0);
    check("rst_data",  out_data,  8'h00);
    check("rst_ready", in_ready,  4'b0000);
    tick;
    check("rst_ready2", in_ready, 4'b0000);

    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;

`ifndef VR_ARB_BURST_EN
    // All requesting: one beat per cycle in index order, wrapping.
    rr_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_ready", in_ready, 4'b0001 << (i % 4));
      tick;
      check("rr_valid", out_valid, 1'b1);
      check("rr_data",  out_data,  rr_exp[i]);
      check("rr_grant", grant_idx, i % 4);
    end

    // ptr=1 now; ch0 and ch3 requesting -> 3, then wrap to 0, then 3.
    in_valid = 4'b1001;
    #1;
    check("wrap_ready0", in_ready, 4'b1000);
    tick;
    check("wrap_grant0", grant_idx, 2'd3);
    check("wrap_data0",  out_data,  8'h13);
    #1;
    check("wrap_ready1", in_ready, 4'b0001);
    tick;
    check("wrap_grant1", grant_idx, 2'd0);
    check("wrap_data1",  out_data,  8'h10);
    tick;
    check("wrap_grant2", grant_idx, 2'd3);

    // Backpressure: ch2 only, first beat A5, second beat 5A held during stall.
    in_valid = 4'b0100;
    in_data[2*W +: W] = 8'hA5;
    #1;
    check("bp_ready0", in_ready, 4'b0100);
    tick;
    check("bp_data0",  out_data,  8'hA5);
    check("bp_grant0", grant_idx, 2'd2);
    in_data[2*W +: W] = 8'h5A;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall_ready", in_ready, 4'b0000);
      tick;
      check("bp_stall_valid", out_valid, 1'b1);
      check("bp_stall_data",  out_data,  8'hA5);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready1", in_ready, 4'b0100);
    tick;
    check("bp_valid1", out_valid, 1'b1);
    check("bp_data1",  out_data,  8'h5A);
    in_valid = 4'b0000;
    tick;
    check("bp_nodup", out_valid, 1'b0);
    in_data[2*W +: W] = 8'h12;

    // Single requester is granted every cycle whatever ptr is.
    in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("single_ready", in_ready, 4'b0010);
      tick;
      check("single_grant", grant_idx, 2'd1);
      check("single_data",  out_data,  8'h11);
    end
`else
    // Burst: ch1 and ch2 requesting, four beats each.
    bst_exp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    in_valid = 4'b0110;
    for (int i = 0; i < 9; i++) begin
      tick;
      check("burst_valid", out_valid, 1'b1);
      check("burst_grant", grant_idx, bst_exp[i]);
    end

    // Restart, then ch1 drops after two beats while ch3 waits.
    rst = 1'b1;
    #1;
    check("burst_rst_valid", out_valid, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 4'b1010;
    tick;
    check("drop_grant0", grant_idx, 2'd1);
    tick;
    check("drop_grant1", grant_idx, 2'd1);
    in_valid = 4'b1000;
    #1;
    check("drop_idle_ready", in_ready, 4'b0000);
    tick;
    check("drop_idle_valid", out_valid, 1'b0);
    #1;
    check("drop_ready3", in_ready, 4'b1000);
    tick;
    check("drop_grant3", grant_idx, 2'd3);
    check("drop_data3",  out_data,  8'h13);
    in_valid = 4'b0010;
`endif

    // Reset mid-stream with a valid beat registered.
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_grant", grant_idx, 2'd0);
    check("mid_rst_data",  out_data,  8'h00);
    check("mid_rst_ready", in_ready,  4'b0000);
    tick;
    check("mid_rst_ready2", in_ready, 4'b0000);
    in_valid = 4'b0110;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 4'b0010);
    tick;
    check("post_rst_grant", grant_idx, 2'd1);
    check("post_rst_data",  out_data,  8'h11);
`ifndef VR_ARB_BURST_EN
    tick;
    check("post_rst_grant2", grant_idx, 2'd2);
    check("post_rst_data2",  out_data,  8'h12);
`endif

    in_valid = 4'b0000;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
